hex_scroll_sequencer: RTL and testbench
=======================================

// Module: hex_scroll_sequencer
//
// PURPOSE
//  Sequencer that owns the four 7-segment displays (HEX3..HEX0) on the board.
//  Raw mode: SW[6:0] drives HEX0 segments directly.
//  Load mode: KEY presses latch up to four SW segment patterns into a buffer.
//  Scroll mode: the buffer rotates across the displays at a fixed tick rate; it can be paused/resumed.
//
// PARAMETERS
//  TICK_DIV    25_000_000  clock cycles per scroll step (>=2)
//  DEB_CYCLES  500_000     cycles a key level must be stable before it is accepted (>=1)
//
// PORTS
//  CLOCK_50  in   1  system clock, all logic on rising edge
//  RESET     in   1  synchronous, active-high reset
//  SW        in   10 SW[6:0] segment pattern; SW[9] scroll direction (0=left, 1=right)
//  KEY       in   4  push buttons, active-low, asynchronous to CLOCK_50
//  HEX3      out  7  segment pattern, active-low (7'h7F = blank), registered
//  HEX2      out  7  as HEX3
//  HEX1      out  7  as HEX3
//  HEX0      out  7  as HEX3
//  STATE     out  2  current FSM state encoding, registered
//
// BEHAVIOUR
//  Reset: STATE=S_RAW; buf[0..3]=7'h7F; wr_ptr=0; offset=0; tick=0; debounce counters=0;
//   HEX3..HEX0=7'h7F on the first cycle after reset.
//  Keys: 2-flop synchroniser per KEY bit, then debounce counter. The accepted level changes
//   only after DEB_CYCLES consecutive equal samples. A press is a 1-cycle pulse on the accepted
//   1->0 transition. Holding a key produces exactly one press.
//  Simultaneous presses in one cycle: only the highest-priority key acts (KEY3>KEY2>KEY1>KEY0).
//  FSM states: S_RAW=2'b00, S_LOAD=2'b01, S_SCROLL=2'b10, S_HOLD=2'b11.
//   S_RAW:    HEX0<=SW[6:0]; HEX3..1<=7'h7F. KEY0 -> S_LOAD, writes SW[6:0] to buf[wr_ptr], wr_ptr++.
//   S_LOAD:   HEXn<=buf[n]. KEY0 writes buf[wr_ptr]<=SW[6:0], wr_ptr<=wr_ptr+1 mod 4; the 5th
//             write overwrites buf[0]. KEY2 sets all buf to 7'h7F and wr_ptr<=0.
//             KEY1 -> S_SCROLL with tick<=0, offset<=0.
//   S_SCROLL: tick counts 0..TICK_DIV-1. On tick==TICK_DIV-1, tick<=0 and offset<=offset+1
//             (SW[9]=0) or offset-1 (SW[9]=1), mod 4 (wraps 3->0 / 0->3).
//             HEXn<=buf[(n+offset) mod 4]. KEY1 -> S_HOLD.
//   S_HOLD:   tick and offset frozen; display as S_SCROLL. KEY1 -> S_SCROLL; tick resumes from
//             its held value (it is not cleared).
//   Any state: KEY3 -> S_RAW, wr_ptr<=0, offset<=0, tick<=0; buffer contents retained.
//  Latency: HEX outputs are registered, 1 cycle after SW/state/offset changes.
//   A press is seen DEB_CYCLES+2 cycles after the KEY pin settles (+1 to the HEX outputs).
//  SW[9] is sampled only at the step edge; changing it mid-step takes effect on the next step.
//  SW[7], SW[8] unused.
//  RESET asserted mid-scroll or mid-debounce: every register returns to its reset value the
//   next edge. A key still held at reset release is not reported as a press.
//
// CONFIGURATION
//  HEX_BLINK_EN defined:
//   In S_HOLD, a free-running blink counter toggles phase every TICK_DIV cycles.
//   In the blank phase all HEX outputs are 7'h7F; in the lit phase they show the normal pattern.
//   The counter clears on entering S_HOLD, so the lit phase comes first.
//  HEX_BLINK_EN undefined: S_HOLD shows a steady display; no blink counter is synthesised.
//
// TESTING  (TICK_DIV=4, DEB_CYCLES=2)
//  1 Reset for 3 cycles -> HEX3..0=7'h7F, STATE=00. SW[6:0]=7'h40 -> HEX0=7'h40 next cycle.
//  2 Load SW=01,02,04,08 via four KEY0 presses, then KEY1 -> STATE=10, HEX3..0=08,04,02,01;
//    after 4 cycles HEX3..0=01,08,04,02; after 16 cycles back to the start pattern.
//  3 Scroll with SW[9]=1 -> offset goes 0,3,2,1,0 on successive steps (wrap check).
//  4 KEY1 mid-step at tick=2 -> STATE=11, display frozen for 20 cycles; KEY1 again ->
//    first step 2 cycles later. With HEX_BLINK_EN: blank/lit toggle every 4 cycles in hold.
//  5 KEY0+KEY3 pressed in the same cycle during S_LOAD -> STATE=00, buf unchanged, wr_ptr=0.
//    KEY bounce shorter than 2 cycles -> no press.
//  6 RESET pulsed in S_SCROLL -> next cycle STATE=00, HEX=7'h7F, buf all 7'h7F;
//    a held KEY0 at release -> no write.

Source files
------------

// File: rtl/hex_scroll_sequencer.sv
// Four-digit 7-segment sequencer: raw SW view, load buffer from KEY presses, scroll/hold rotation.
// Optional macro HEX_BLINK_EN: blinks the display while scrolling is held.
module hex_scroll_sequencer #(
   parameter int TICK_DIV   = 25_000_000,
   parameter int DEB_CYCLES = 500_000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [9:0] SW,
   input  logic [3:0] KEY,
   output logic [6:0] HEX3,
   output logic [6:0] HEX2,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
   output logic [1:0] STATE
);

   // state    | meaning
   // S_RAW    | HEX0 mirrors SW[6:0], other digits blank
   // S_LOAD   | KEY0 appends SW[6:0] to the buffer, KEY2 clears it, KEY1 starts scrolling
   // S_SCROLL | buffer rotates one digit every TICK_DIV cycles, KEY1 pauses
   // S_HOLD   | rotation frozen (tick and offset kept), KEY1 resumes
   typedef enum logic [1:0] {
      S_RAW    = 2'b00,
      S_LOAD   = 2'b01,
      S_SCROLL = 2'b10,
      S_HOLD   = 2'b11
   } state_t;

   localparam int TW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [6:0]    BLANK     = 7'h7F;

   logic [3:0]    key_s1, key_s2, key_acc, press, key_act;
   logic [DW-1:0] deb_cnt [4];

   state_t        state, state_nxt;
   logic [6:0]    seg_buf [4];
   logic [6:0]    seg_buf_nxt [4];
   logic [1:0]    wr_ptr, wr_ptr_nxt;
   logic [1:0]    offset, offset_nxt;
   logic [TW-1:0] tick, tick_nxt;
   logic [6:0]    hex_nxt [4];

   logic unused_sw;
   assign unused_sw = ^SW[8:7];

   // Sync flops and accepted level reset to "pressed" so a key held through
   // reset must first be seen released before it can produce a press.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         key_s1  <= '0;
         key_s2  <= '0;
         key_acc <= '0;
         press   <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         key_s1 <= KEY;
         key_s2 <= key_s1;
         for (int i = 0; i < 4; i++) begin
            press[i] <= 1'b0;
            if (key_s2[i] == key_acc[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_cnt[i] <= '0;
               key_acc[i] <= key_s2[i];
               press[i]   <= ~key_s2[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   always_comb begin
      key_act = '0;
      if (press[3])      key_act[3] = 1'b1;
      else if (press[2]) key_act[2] = 1'b1;
      else if (press[1]) key_act[1] = 1'b1;
      else if (press[0]) key_act[0] = 1'b1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state  <= S_RAW;
         wr_ptr <= '0;
         offset <= '0;
         tick   <= '0;
         for (int i = 0; i < 4; i++) seg_buf[i] <= BLANK;
      end else begin
         state  <= state_nxt;
         wr_ptr <= wr_ptr_nxt;
         offset <= offset_nxt;
         tick   <= tick_nxt;
         for (int i = 0; i < 4; i++) seg_buf[i] <= seg_buf_nxt[i];
      end
   end

   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      offset_nxt = offset;
      tick_nxt   = tick;
      for (int i = 0; i < 4; i++) seg_buf_nxt[i] = seg_buf[i];

      if (key_act[3]) begin
         state_nxt  = S_RAW;
         wr_ptr_nxt = '0;
         offset_nxt = '0;
         tick_nxt   = '0;
      end else begin
         case (state)
            S_RAW: begin
               if (key_act[0]) begin
                  seg_buf_nxt[wr_ptr] = SW[6:0];
                  wr_ptr_nxt          = wr_ptr + 2'd1;
                  state_nxt           = S_LOAD;
               end
            end
            S_LOAD: begin
               if (key_act[0]) begin
                  seg_buf_nxt[wr_ptr] = SW[6:0];
                  wr_ptr_nxt          = wr_ptr + 2'd1;
               end else if (key_act[2]) begin
                  for (int i = 0; i < 4; i++) seg_buf_nxt[i] = BLANK;
                  wr_ptr_nxt = '0;
               end else if (key_act[1]) begin
                  state_nxt  = S_SCROLL;
                  tick_nxt   = '0;
                  offset_nxt = '0;
               end
            end
            S_SCROLL: begin
               if (key_act[1]) begin
                  state_nxt = S_HOLD;
               end else if (tick == TICK_LAST) begin
                  tick_nxt   = '0;
                  offset_nxt = SW[9] ? offset - 2'd1 : offset + 2'd1;
               end else begin
                  tick_nxt = tick + TW'(1);
               end
            end
            S_HOLD: begin
               if (key_act[1]) state_nxt = S_SCROLL;
            end
         endcase
      end
   end

`ifdef HEX_BLINK_EN
   logic [TW-1:0] blink_cnt;
   logic          blink_off;

   // Held at zero outside S_HOLD, so every hold starts with the lit phase.
   always_ff @(posedge CLOCK_50) begin
      if (RESET || state != S_HOLD) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (blink_cnt == TICK_LAST) begin
         blink_cnt <= '0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + TW'(1);
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < 4; i++) hex_nxt[i] = BLANK;
      case (state)
         S_RAW:  hex_nxt[0] = SW[6:0];
         S_LOAD: for (int i = 0; i < 4; i++) hex_nxt[i] = seg_buf[i];
         S_SCROLL, S_HOLD:
            for (int i = 0; i < 4; i++) hex_nxt[i] = seg_buf[2'(i) + offset];
      endcase
`ifdef HEX_BLINK_EN
      if (state == S_HOLD && blink_off)
         for (int i = 0; i < 4; i++) hex_nxt[i] = BLANK;
`endif
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         HEX0 <= BLANK;
         HEX1 <= BLANK;
         HEX2 <= BLANK;
         HEX3 <= BLANK;
      end else begin
         HEX0 <= hex_nxt[0];
         HEX1 <= hex_nxt[1];
         HEX2 <= hex_nxt[2];
         HEX3 <= hex_nxt[3];
      end
   end

   assign STATE = state;

endmodule

// File: tb/tb_hex_scroll_sequencer.sv
// Directed bench for hex_scroll_sequencer with TICK_DIV=4, DEB_CYCLES=2.
module tb_hex_scroll_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sw;
   logic [3:0] key;
   logic [6:0] hex3, hex2, hex1, hex0;
   logic [1:0] state;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   hex_scroll_sequencer #(.TICK_DIV(4), .DEB_CYCLES(2)) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .SW       (sw),
      .KEY      (key),
      .HEX3     (hex3),
      .HEX2     (hex2),
      .HEX1     (hex1),
      .HEX0     (hex0),
      .STATE    (state)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(input logic [6:0] a, input logic [6:0] b,
                                      input logic [6:0] c, input logic [6:0] d);
      return {4'h0, a, b, c, d};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the negedge right after the FSM has acted on the press.
   task automatic key_down(input logic [3:0] mask);
      key = key & ~mask;
      cyc(5);
   endtask

   task automatic key_up(input logic [3:0] mask);
      key = key | mask;
      cyc(6);
   endtask

   task automatic tap(input logic [3:0] mask);
      key_down(mask);
      key_up(mask);
   endtask

   task automatic chk_hex(input string tag, input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] c, input logic [6:0] d);
      check_val(tag, pk(hex3, hex2, hex1, hex0), pk(a, b, c, d));
   endtask

   initial begin
      rst = 1'b1;
      sw  = '0;
      key = 4'hF;
      cyc(3);
      check_val("rst_state", 32'(state), 32'h0);
      chk_hex("rst_hex", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      rst = 1'b0;
      sw  = 10'h040;
      cyc(1);
      chk_hex("raw_sw40", 7'h7F, 7'h7F, 7'h7F, 7'h40);
      cyc(6);

      // load four patterns and scroll left
      sw = 10'h001; tap(4'b0001);
      check_val("raw_to_load", 32'(state), 32'h1);
      sw = 10'h002; tap(4'b0001);
      sw = 10'h004; tap(4'b0001);
      sw = 10'h008; tap(4'b0001);
      chk_hex("load_four", 7'h08, 7'h04, 7'h02, 7'h01);
      key_down(4'b0010);
      check_val("scroll_state", 32'(state), 32'h2);
      cyc(1);  chk_hex("scr_off0", 7'h08, 7'h04, 7'h02, 7'h01);
      cyc(4);  chk_hex("scr_off1", 7'h01, 7'h08, 7'h04, 7'h02);
      cyc(4);  chk_hex("scr_off2", 7'h02, 7'h01, 7'h08, 7'h04);
      cyc(8);  chk_hex("scr_wrap", 7'h08, 7'h04, 7'h02, 7'h01);
      key_up(4'b0010);

      // scroll right: offsets 0,3,2,1,0
      key_down(4'b1000);
      check_val("key3_raw", 32'(state), 32'h0);
      key_up(4'b1000);
      sw = 10'h001; tap(4'b0001);
      sw = 10'h201;
      key_down(4'b0010);
      cyc(1);  chk_hex("right_off0", 7'h08, 7'h04, 7'h02, 7'h01);
      cyc(4);  chk_hex("right_off3", 7'h04, 7'h02, 7'h01, 7'h08);
      cyc(4);  chk_hex("right_off2", 7'h02, 7'h01, 7'h08, 7'h04);
      cyc(4);  chk_hex("right_off1", 7'h01, 7'h08, 7'h04, 7'h02);
      cyc(4);  chk_hex("right_off0b", 7'h08, 7'h04, 7'h02, 7'h01);
      key_up(4'b0010);

      // hold at tick=2 / offset=2, then resume from the held tick
      tap(4'b1000);
      sw = 10'h001; tap(4'b0001);
      key_down(4'b0010);
      key_up(4'b0010);
      key_down(4'b0010);
      check_val("hold_state", 32'(state), 32'h3);
      chk_hex("hold_entry", 7'h02, 7'h01, 7'h08, 7'h04);
      key_up(4'b0010);
`ifdef HEX_BLINK_EN
      chk_hex("hold_blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
      chk_hex("hold_frozen6", 7'h02, 7'h01, 7'h08, 7'h04);
`endif
      cyc(14);
      chk_hex("hold_frozen20", 7'h02, 7'h01, 7'h08, 7'h04);
      key_down(4'b0010);
      check_val("resume_state", 32'(state), 32'h2);
      cyc(2);  chk_hex("resume_pre", 7'h02, 7'h01, 7'h08, 7'h04);
      cyc(1);  chk_hex("resume_step", 7'h04, 7'h02, 7'h01, 7'h08);
      key_up(4'b0010);

      // KEY3 beats KEY0; wr_ptr rewinds; buffer kept
      tap(4'b1000);
      sw = 10'h011; tap(4'b0001);
      chk_hex("load_11", 7'h08, 7'h04, 7'h02, 7'h11);
      sw = 10'h022;
      key_down(4'b1001);
      check_val("prio_state", 32'(state), 32'h0);
      key_up(4'b1001);
      sw = 10'h033; tap(4'b0001);
      check_val("prio_load", 32'(state), 32'h1);
      chk_hex("prio_buf", 7'h08, 7'h04, 7'h02, 7'h33);

      // one-cycle glitch must not register
      sw = 10'h055;
      key[0] = 1'b0; cyc(1); key[0] = 1'b1;
      cyc(8);
      chk_hex("bounce", 7'h08, 7'h04, 7'h02, 7'h33);
      sw = 10'h044; tap(4'b0001);
      chk_hex("load_44", 7'h08, 7'h04, 7'h44, 7'h33);
      tap(4'b0100);
      check_val("clear_state", 32'(state), 32'h1);
      chk_hex("clear_buf", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      for (int i = 0; i < 5; i++) begin
         sw = 10'(7'h0A + i);
         tap(4'b0001);
      end
      chk_hex("fifth_wr", 7'h0D, 7'h0C, 7'h0B, 7'h0E);

      // reset mid-scroll with KEY0 held across release
      tap(4'b0010);
      cyc(3);
      rst = 1'b1;
      key[0] = 1'b0;
      cyc(1);
      check_val("midrst_state", 32'(state), 32'h0);
      chk_hex("midrst_hex", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      cyc(1);
      rst = 1'b0;
      cyc(10);
      check_val("held_nopress", 32'(state), 32'h0);
      key_up(4'b0001);
      check_val("held_release", 32'(state), 32'h0);
      sw = 10'h05A; tap(4'b0001);
      check_val("post_rst_load", 32'(state), 32'h1);
      chk_hex("post_rst_buf", 7'h7F, 7'h7F, 7'h7F, 7'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
